// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the RAM arbiter.
// Holds the arbiter state enum, the default bus widths and the
// control-word bit positions of the MI/RR/RW/HLT strobes.
package ram_arb_pkg;

  localparam int ARB_ADDR_W = 4;
  localparam int ARB_DATA_W = 8;

  // Control-word bit positions, for callers that slice a full control word.
  localparam int MI_BIT  = 11;
  localparam int RR_BIT  = 10;
  localparam int RW_BIT  = 9;
  localparam int HLT_BIT = 15;

  typedef enum logic [1:0] {
    ARB_CPU     = 2'd0,
    ARB_LDR     = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ram_arb_mar.sv
// ram_arb_mar: memory address register with load enable.
module ram_arb_mar #(
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);

  // Capture the new address on load; otherwise hold.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the program/data RAM between the CPU control path
// and an external program loader. The loader only takes the RAM at an
// instruction boundary or while the CPU is halted; the sequencer is
// stalled for the whole grant plus one release cycle.
// Optional feature: define RAM_ARB_WP_EN to block CPU writes at or above
// WP_BASE and raise a sticky wp_fault.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int                ADDR_W  = ARB_ADDR_W,
  parameter int                DATA_W  = ARB_DATA_W,
  parameter logic [ADDR_W-1:0] WP_BASE = 4'hC
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cpu_mi,
  input  logic              cpu_rr,
  input  logic              cpu_rw,
  input  logic [DATA_W-1:0] cpu_bus_in,
  input  logic              cpu_boundary,
  input  logic              cpu_hlt,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_done,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              wp_fault
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mar_q;
  logic              cpu_own;
  logic              ldr_acc;
  logic              wp_block;

  assign cpu_own = (state_q == ARB_CPU);
  // A loader access is any granted cycle with the request still held.
  assign ldr_acc = (state_q == ARB_LDR) & ldr_req;

  // CPU strobes only act while the CPU owns the RAM.
  ram_arb_mar #(.ADDR_W(ADDR_W)) u_mar (
    .CLK  (CLK),
    .RST_N(RST_N),
    .load (cpu_own & cpu_mi),
    .d    (cpu_bus_in[ADDR_W-1:0]),
    .q    (mar_q)
  );

`ifdef RAM_ARB_WP_EN
  assign wp_block = cpu_own & cpu_rw & (mar_q >= WP_BASE);

  // Sticky fault: set by any blocked CPU write, cleared only by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        wp_fault <= 1'b0;
    else if (wp_block) wp_fault <= 1'b1;
  end
`else
  assign wp_block = 1'b0;
  assign wp_fault = 1'b0;
`endif

  // Ownership state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ARB_CPU;
    else        state_q <= state_d;
  end

  // Next ownership: grant at boundary/halt, release takes one extra cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_CPU:     if (ldr_req & (cpu_boundary | cpu_hlt)) state_d = ARB_LDR;
      ARB_LDR:     if (!ldr_req)                           state_d = ARB_RELEASE;
      ARB_RELEASE: state_d = ARB_CPU;
      default:     state_d = ARB_CPU;
    endcase
  end

  // Grant/stall are registered from the next state so they change on the
  // same edge as the ownership itself; loader completion lags one cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ldr_gnt   <= 1'b0;
      cpu_stall <= 1'b0;
      ldr_done  <= 1'b0;
      ldr_rdata <= '0;
    end else begin
      ldr_gnt   <= (state_d == ARB_LDR);
      cpu_stall <= (state_d != ARB_CPU);
      ldr_done  <= ldr_acc;
      if (ldr_acc) ldr_rdata <= ram_rdata;
    end
  end

  // RAM port steering. The release cycle is idle: MAR on the address bus,
  // no write, nothing driven to the CPU bus.
  always_comb begin
    ram_addr    = mar_q;
    ram_we      = 1'b0;
    ram_wdata   = cpu_bus_in;
    cpu_rd_data = '0;
    unique case (state_q)
      ARB_CPU: begin
        ram_we      = cpu_rw & ~wp_block;
        cpu_rd_data = cpu_rr ? ram_rdata : '0;
      end
      ARB_LDR: begin
        ram_addr  = ldr_addr;
        ram_we    = ldr_acc & ldr_we;
        ram_wdata = ldr_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed + randomized bench for ram_arbiter with a
// scoreboard. The driver pushes per-cycle expectations and expected loader
// read data; a negedge monitor pops and compares.
module tb_ram_arbiter;

  localparam logic [3:0] WPB = 4'hC;
`ifdef RAM_ARB_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  logic       CLK = 1'b0, RST_N = 1'b0;
  logic       cpu_mi = 0, cpu_rr = 0, cpu_rw = 0, cpu_boundary = 0, cpu_hlt = 0;
  logic [7:0] cpu_bus_in = '0;
  logic [7:0] cpu_rd_data;
  logic       cpu_stall;
  logic       ldr_req = 0, ldr_we = 0;
  logic [3:0] ldr_addr = '0;
  logic [7:0] ldr_wdata = '0;
  logic       ldr_gnt, ldr_done;
  logic [7:0] ldr_rdata;
  logic [3:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata, ram_rdata;
  logic       wp_fault;

  always #5 CLK = ~CLK;

  ram_arbiter #(.ADDR_W(4), .DATA_W(8), .WP_BASE(WPB)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cpu_mi(cpu_mi), .cpu_rr(cpu_rr), .cpu_rw(cpu_rw), .cpu_bus_in(cpu_bus_in),
    .cpu_boundary(cpu_boundary), .cpu_hlt(cpu_hlt),
    .cpu_rd_data(cpu_rd_data), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_done(ldr_done), .ldr_rdata(ldr_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .wp_fault(wp_fault)
  );

  // RAM macro: async read, sync write.
  logic [7:0] ram [16];
  assign ram_rdata = ram[ram_addr];
  always @(posedge CLK) if (ram_we) ram[ram_addr] <= ram_wdata;

  // Expected per-cycle view of the DUT outputs.
  typedef struct {
    logic       gnt, stall, done, we, wpf, chk_addr;
    logic [3:0] addr;
    logic [7:0] wdata, rd;
  } exp_t;

  exp_t       cyc_q[$];
  logic [7:0] ldr_q[$];

  // Reference model: owner (0 CPU, 1 loader, 2 handing back), MAR, memory.
  int         m_mode = 0;
  logic [3:0] m_mar  = '0;
  logic       m_wp   = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] ref_mem [16];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, record what the DUT should show this cycle,
  // then advance the model across the coming edge.
  task automatic drive(input logic mi, rr, rw, input logic [7:0] bus,
                       input logic bnd, hlt, req, we,
                       input logic [3:0] la, input logic [7:0] lw);
    exp_t e;
    logic prot;
    @(posedge CLK); #1;
    cpu_mi = mi; cpu_rr = rr; cpu_rw = rw; cpu_bus_in = bus;
    cpu_boundary = bnd; cpu_hlt = hlt;
    ldr_req = req; ldr_we = we; ldr_addr = la; ldr_wdata = lw;

    e.gnt = (m_mode == 1); e.stall = (m_mode != 0);
    e.done = m_done; e.wpf = m_wp;
    e.we = 1'b0; e.rd = '0; e.addr = m_mar; e.wdata = bus; e.chk_addr = 1'b1;
    prot = WP_ON && rw && (m_mar >= WPB);
    if (m_mode == 0) begin
      e.we = rw && !prot;
      e.rd = rr ? ref_mem[m_mar] : 8'h00;
    end else if (m_mode == 1) begin
      e.addr = la; e.we = req && we; e.wdata = lw;
    end else begin
      e.chk_addr = 1'b0;
    end
    cyc_q.push_back(e);

    m_done = (m_mode == 1) && req;
    if (m_mode == 1) begin
      if (req) ldr_q.push_back(ref_mem[la]);
      if (req && we) ref_mem[la] = lw;
      if (!req) m_mode = 2;
    end else if (m_mode == 2) begin
      m_mode = 0;
    end else begin
      if (e.we) ref_mem[m_mar] = bus;
      if (prot) m_wp = 1'b1;
      if (mi) m_mar = bus[3:0];
      if (req && (bnd || hlt)) m_mode = 1;
    end
  endtask

  task automatic idle(input logic req);
    drive(0, 0, 0, 8'h00, 0, 0, req, 0, 4'h0, 8'h00);
  endtask

  // Monitor: compare every presented cycle and every loader completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("ldr_gnt", ldr_gnt, e.gnt);
        chk("cpu_stall", cpu_stall, e.stall);
        chk("ldr_done", ldr_done, e.done);
        chk("ram_we", ram_we, e.we);
        if (e.we) chk("ram_wdata", ram_wdata, e.wdata);
        if (e.chk_addr) chk("ram_addr", ram_addr, e.addr);
        chk("cpu_rd_data", cpu_rd_data, e.rd);
        chk("wp_fault", wp_fault, e.wpf);
      end
      if (ldr_done === 1'b1) begin
        if (ldr_q.size() == 0) chk("ldr_done_unexpected", 1, 0);
        else chk("ldr_rdata", ldr_rdata, ldr_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic r_req, mi, rr, rw, bnd, hlt;
    int   k;
    for (int i = 0; i < 16; i++) begin ram[i] = 8'h00; ref_mem[i] = 8'h00; end

    // Reset values
    #2;
    chk("rst_gnt", ldr_gnt, 0);   chk("rst_stall", cpu_stall, 0);
    chk("rst_done", ldr_done, 0); chk("rst_rdata", ldr_rdata, 0);
    chk("rst_wpf", wp_fault, 0);  chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0); chk("rst_rd", cpu_rd_data, 0);
    #10 RST_N = 1'b1;

    // CPU path: MAR=5, write A7, read back
    drive(1, 0, 0, 8'h05, 0, 0, 0, 0, 4'h0, 8'h00);
    drive(0, 0, 1, 8'hA7, 0, 0, 0, 0, 4'h0, 8'h00);
    drive(0, 1, 0, 8'h00, 1, 0, 0, 0, 4'h0, 8'h00);
    chk("ram5", ram[5], 8'hA7);

    // Grant at boundary, loader writes 3C to addr 2, then release
    drive(0, 0, 0, 8'h00, 1, 0, 1, 1, 4'h2, 8'h3C);
    drive(0, 0, 0, 8'h00, 0, 0, 1, 1, 4'h2, 8'h3C);
    idle(0); idle(0); idle(0);
    chk("ram2", ram[2], 8'h3C);

    // Blocked mid-instruction: CPU keeps working, then grant at boundary
    drive(1, 0, 0, 8'h07, 0, 0, 1, 0, 4'h7, 8'h00);
    drive(0, 0, 1, 8'h11, 0, 0, 1, 0, 4'h7, 8'h00);
    drive(0, 1, 0, 8'h00, 0, 0, 1, 0, 4'h7, 8'h00);
    drive(0, 0, 0, 8'h00, 1, 0, 1, 0, 4'h7, 8'h00);
    drive(0, 0, 0, 8'h00, 0, 0, 1, 0, 4'h7, 8'h00);
    idle(0); idle(0); idle(0);

    // Halted CPU: grant without boundary, read back addr 2, then reset mid-grant
    drive(0, 0, 0, 8'h00, 0, 1, 1, 0, 4'h2, 8'h00);
    drive(0, 0, 0, 8'h00, 0, 1, 1, 0, 4'h2, 8'h00);
    drive(0, 0, 0, 8'h00, 0, 1, 1, 1, 4'h9, 8'h55);
    @(posedge CLK); #1;
    RST_N = 1'b0; cpu_rw = 0; cpu_hlt = 0; ldr_req = 1; ldr_we = 1; ldr_addr = 4'h9;
    #1;
    chk("arst_gnt", ldr_gnt, 0);   chk("arst_stall", cpu_stall, 0);
    chk("arst_done", ldr_done, 0); chk("arst_we", ram_we, 0);
    chk("arst_mar", ram_addr, 0);  chk("arst_rdata", ldr_rdata, 0);
    ldr_q.delete();
    m_mode = 0; m_mar = '0; m_wp = 1'b0; m_done = 1'b0;
    @(posedge CLK); #1;
    chk("arst_we_hold", ram_we, 0);
    chk("ram9", ram[9], 8'h55);
    @(negedge CLK);
    RST_N = 1'b1; ldr_req = 0; ldr_we = 0;
    idle(0); idle(0);

    // Write-protect window (writes pass when the feature is compiled out)
    drive(1, 0, 0, 8'h0D, 0, 0, 0, 0, 4'h0, 8'h00);
    drive(0, 0, 1, 8'hFF, 0, 0, 0, 0, 4'h0, 8'h00);
    idle(0); idle(0);
    chk("ramD_cpu", ram[13], WP_ON ? 8'h00 : 8'hFF);
    drive(0, 0, 0, 8'h00, 1, 0, 1, 1, 4'hD, 8'h5A);
    drive(0, 0, 0, 8'h00, 0, 0, 1, 1, 4'hD, 8'h5A);
    idle(0); idle(0); idle(0);
    chk("ramD_ldr", ram[13], 8'h5A);

    // Randomized traffic
    r_req = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) r_req = ~r_req;
      mi = 0; rr = 0; rw = 0;
      bnd = ($urandom_range(0, 3) == 0);
      hlt = ($urandom_range(0, 15) == 0);
      if (m_mode != 2) begin
        mi = ($urandom_range(0, 3) == 0);
        rr = $urandom_range(0, 1);
        rw = ($urandom_range(0, 3) == 0);
      end
      drive(mi, rr, rw, 8'($urandom), bnd, hlt, r_req, 1'($urandom),
            4'($urandom), 8'($urandom));
    end

    // Drain back to CPU ownership
    k = 0;
    while (m_mode != 0 && k < 10) begin idle(0); k++; end
    chk("drain", m_mode, 0);
    idle(0);
    @(negedge CLK); @(negedge CLK);
    for (int i = 0; i < 16; i++) chk("mem", ram[i], ref_mem[i]);
    chk("ldr_q_left", ldr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
